// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ping-pong 16-sample frame buffer feeding the FFT push/stall input
// Fills one bank from upstream while the other drains through a one-entry output register.
module fft_frame_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_push,
  input  logic [WIDTH-1:0] ld_real,
  input  logic [WIDTH-1:0] ld_imag,
  output logic             ld_stall,
  input  logic             bitrev_en,
  output logic             out_push,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  input  logic             out_stall,
  output logic             frame_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [WIDTH-1:0] r_mem_re [2*N];
  logic [WIDTH-1:0] r_mem_im [2*N];

  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic [AW-1:0]    r_wr_cnt;
  logic             r_rd_bank;
  logic [AW-1:0]    r_rd_cnt;
  logic             r_brev;
  logic             r_out_push;
  logic             r_out_last;
  logic [WIDTH-1:0] r_out_real;
  logic [WIDTH-1:0] r_out_imag;
  logic             r_frame_done;

  logic             w_ld_acc;
  logic             w_ld_last;
  logic             w_out_load;
  logic             w_rd_go;
  logic             w_rd_last;
  logic             w_brev;
  logic [AW-1:0]    w_rd_idx;
  logic [1:0]       w_full_nxt;
  logic [AW:0]      w_wr_addr;
  logic [AW:0]      w_rd_addr;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  assign ld_stall   = r_full[r_wr_bank];
  assign out_push   = r_out_push;
  assign out_real   = r_out_real;
  assign out_imag   = r_out_imag;
  assign frame_done = r_frame_done;

  assign w_ld_acc   = ld_push && !r_full[r_wr_bank];
  assign w_ld_last  = w_ld_acc && (r_wr_cnt == LAST_IDX);
  assign w_out_load = !r_out_push || !out_stall;
  assign w_rd_go    = w_out_load && r_full[r_rd_bank];
  assign w_rd_last  = w_rd_go && (r_rd_cnt == LAST_IDX);

  // Order is chosen at the first load of a frame; index 0 is the same either way.
  assign w_brev     = (r_rd_cnt == '0) ? bitrev_en : r_brev;
  assign w_rd_idx   = w_brev ? f_bitrev(r_rd_cnt) : r_rd_cnt;
  assign w_wr_addr  = {r_wr_bank, r_wr_cnt};
  assign w_rd_addr  = {r_rd_bank, w_rd_idx};

  // Fill only ever targets a non-full bank and release only a full one, so they never collide.
  always_comb begin
    w_full_nxt = r_full;
    for (int b = 0; b < 2; b++) begin
      if (w_ld_last && (r_wr_bank == b[0])) w_full_nxt[b] = 1'b1;
      if (w_rd_last && (r_rd_bank == b[0])) w_full_nxt[b] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_acc) begin
      r_mem_re[w_wr_addr] <= ld_real;
      r_mem_im[w_wr_addr] <= ld_imag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full       <= '0;
      r_wr_bank    <= 1'b0;
      r_wr_cnt     <= '0;
      r_rd_bank    <= 1'b0;
      r_rd_cnt     <= '0;
      r_brev       <= 1'b0;
      r_out_push   <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_real   <= '0;
      r_out_imag   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_full       <= w_full_nxt;
      r_frame_done <= r_out_push && !out_stall && r_out_last;

      if (w_ld_acc) begin
        r_wr_cnt <= w_ld_last ? '0 : r_wr_cnt + AW'(1);
        if (w_ld_last) r_wr_bank <= ~r_wr_bank;
      end

      if (w_out_load) begin
        r_out_push <= w_rd_go;
        r_out_last <= w_rd_last;
        if (w_rd_go) begin
          r_out_real <= r_mem_re[w_rd_addr];
          r_out_imag <= r_mem_im[w_rd_addr];
          r_brev     <= w_brev;
          r_rd_cnt   <= w_rd_last ? '0 : r_rd_cnt + AW'(1);
          if (w_rd_last) r_rd_bank <= ~r_rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - scoreboard bench for fft_frame_feeder
module tb_fft_frame_feeder;

  logic        clk;
  logic        reset;
  logic        ld_push;
  logic [15:0] ld_real;
  logic [15:0] ld_imag;
  logic        ld_stall;
  logic        bitrev_en;
  logic        out_push;
  logic [15:0] out_real;
  logic [15:0] out_imag;
  logic        out_stall;
  logic        frame_done;

  fft_frame_feeder #(.WIDTH(16), .N(16), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .ld_push(ld_push), .ld_real(ld_real), .ld_imag(ld_imag), .ld_stall(ld_stall),
    .bitrev_en(bitrev_en),
    .out_push(out_push), .out_real(out_real), .out_imag(out_imag), .out_stall(out_stall),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int stall_seen = 0;
  int xfer_first = -1;
  int xfer_last = -1;
  int stg_n = 0;
  int br_tab [16];
  logic [31:0] stg [16];
  logic [31:0] exp_q [$];
  logic cur_brev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every transfer to the FFT pops one expected sample.
  always @(negedge clk) begin
    if (reset && out_push && !out_stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %0d/%0d, required no output", $signed(out_real), $signed(out_imag));
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({out_real, out_imag} !== e) begin
          errors++;
          $display("FAIL sb_data: got %0d/%0d, required %0d/%0d", $signed(out_real), $signed(out_imag),
                   $signed(e[31:16]), $signed(e[15:0]));
        end
      end
      if (xfer_first < 0) xfer_first = cyc;
      xfer_last = cyc;
    end
    if (frame_done) n_done++;
  end

  task automatic push_sample(input logic [15:0] re, input logic [15:0] im);
    int t;
    ld_push = 1'b1; ld_real = re; ld_imag = im; t = 0;
    forever begin
      @(negedge clk);
      if (!ld_stall) break;
      stall_seen++;
      t++;
      if (t > 500) begin
        checks++; errors++;
        $display("FAIL push_timeout: ld_stall stuck at 1, required accept");
        ld_push = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    ld_push = 1'b0;
    n_acc++;
    stg[stg_n] = {re, im};
    stg_n++;
    if (stg_n == 16) begin
      for (int j = 0; j < 16; j++) exp_q.push_back(cur_brev ? stg[br_tab[j]] : stg[j]);
      stg_n = 0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d samples missing, required 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    stg_n = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_push, ld_stall, frame_done, out_real, out_imag} !== 35'd0) begin
      errors++;
      $display("FAIL reset_state: push=%b stall=%b done=%b re=%0d im=%0d, required all 0",
               out_push, ld_stall, frame_done, out_real, out_imag);
    end
  endtask

  task automatic test_impulse();
    int d0;
    d0 = n_done;
    push_sample(16'h7FFF, 16'h0);
    for (int i = 1; i < 16; i++) push_sample(16'h0, 16'h0);
    checks++;
    if (out_push !== 1'b0) begin
      errors++; $display("FAIL imp_early: out_push=%b, required 0", out_push);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_push !== 1'b1) begin
        errors++; $display("FAIL imp_contig[%0d]: out_push=%b, required 1", i, out_push);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_push !== 1'b0 || frame_done !== 1'b1) begin
      errors++; $display("FAIL imp_end: out_push=%b frame_done=%b, required 0/1", out_push, frame_done);
    end
    wait_drain("impulse");
    checks++;
    if (n_done - d0 != 1) begin
      errors++; $display("FAIL imp_done_cnt: %0d pulses, required 1", n_done - d0);
    end
  endtask

  task automatic test_bitrev();
    bitrev_en = 1'b1; cur_brev = 1'b1;
    for (int i = 0; i < 16; i++) push_sample(16'(i), 16'(-i));
    wait_drain("bitrev");
    bitrev_en = 1'b0; cur_brev = 1'b0;
  endtask

  task automatic test_out_stall();
    int t;
    for (int i = 0; i < 16; i++) push_sample(16'(i), 16'(100 + i));
    t = 0;
    while (!(out_push && out_real == 16'd5) && t < 100) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (t >= 100) begin
      errors++; $display("FAIL stall_find: out_real=%0d never 5, required 5", out_real);
    end
    out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_real !== 16'd5 || out_push !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: out_real=%0d push=%b, required 5/1", i, out_real, out_push);
      end
    end
    out_stall = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_backpressure();
    out_stall = 1'b1;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) push_sample(16'(i), 16'(~i));
      end
      begin
        int t;
        t = 0;
        while (n_acc < 32 && t < 500) begin
          @(negedge clk); t++;
        end
        checks++;
        if (ld_stall !== 1'b1 || n_acc != 32) begin
          errors++; $display("FAIL bp_stall_rise: ld_stall=%b accepts=%0d, required 1/32", ld_stall, n_acc);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (n_acc != 32) begin
          errors++; $display("FAIL bp_hold: accepts=%0d, required 32", n_acc);
        end
        @(posedge clk); #1;
        out_stall = 1'b0;
      end
    join
    wait_drain("backpressure");
    checks++;
    if (n_acc != 40) begin
      errors++; $display("FAIL bp_accepts: %0d, required 40", n_acc);
    end
  endtask

  task automatic test_back_to_back();
    int d0, s0;
    d0 = n_done; s0 = stall_seen;
    xfer_first = -1;
    for (int i = 0; i < 64; i++) push_sample(16'(1000 + 3 * i), 16'(-7 * i));
    wait_drain("stream");
    checks++;
    if (stall_seen != s0) begin
      errors++; $display("FAIL stream_ld_stall: %0d stalled cycles, required 0", stall_seen - s0);
    end
    checks++;
    if (xfer_last - xfer_first != 63) begin
      errors++; $display("FAIL stream_contig: span %0d cycles, required 63", xfer_last - xfer_first);
    end
    checks++;
    if (n_done - d0 != 4) begin
      errors++; $display("FAIL stream_done_cnt: %0d pulses, required 4", n_done - d0);
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 7; i++) push_sample(16'h5A5A, 16'hA5A5);
    reset = 1'b0;
    #1;
    checks++;
    if ({out_push, ld_stall, frame_done, out_real, out_imag} !== 35'd0) begin
      errors++;
      $display("FAIL midrst_state: push=%b stall=%b done=%b re=%0d im=%0d, required all 0",
               out_push, ld_stall, frame_done, out_real, out_imag);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    stg_n = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) push_sample(16'($urandom), 16'($urandom));
    wait_drain("midrst");
  endtask

  initial begin
    br_tab = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    reset = 1'b0; ld_push = 1'b0; ld_real = '0; ld_imag = '0;
    bitrev_en = 1'b0; out_stall = 1'b0;
    test_reset();
    test_impulse();
    test_bitrev();
    test_out_stall();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
